led_pattern_engine: RTL

//  Parametrised LED pattern sequencer driven by board switches.
//  A prescaler produces a step tick; a mode FSM advances an LED_W-bit pattern on each tick.

---
 rtl/led_pattern_engine.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: a prescaler generates a step tick and a mode FSM
// advances an LED_W-bit pattern (hold, rotate left/right, alternate, bounce, off).
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RESET  in   1      asynchronous active-low reset
//   SW     in   4      mode select switches
//   SPEED  in   2      rate select, step limit = TICK_MAX >> SPEED
//   PAUSE  in   1      1 freezes prescaler and pattern
//   LED    out  LED_W  pattern output (registered)
//   TICK   out  1      one-cycle pulse after each pattern step (registered)
//   MODE   out  3      current mode code (registered)
module led_pattern_engine #(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned TICK_MAX = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       SW,
    input  logic [1:0]       SPEED,
    input  logic             PAUSE,
    output logic [LED_W-1:0] LED,
    output logic             TICK,
    output logic [2:0]       MODE
);

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_HOLD   = 3'd1,
        M_LEFT   = 3'd2,
        M_RIGHT  = 3'd3,
        M_ALT    = 3'd4,
        M_BOUNCE = 3'd5
    } mode_t;

    // Alternating seed anchored at the MSB: 1010..10
    function automatic logic [LED_W-1:0] alt_pattern();
        logic [LED_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (((int'(LED_W) - 1 - i) % 2) == 0) v[i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [CNT_W-1:0] LIMIT_BASE = CNT_W'(TICK_MAX);
    localparam logic [LED_W-1:0] LED_ONE    = LED_W'(1);
    localparam logic [LED_W-1:0] LED_MSB    = LED_ONE << (LED_W - 1);
    localparam logic [LED_W-1:0] ALT_SEED   = alt_pattern();
    localparam logic             DIR_UP     = 1'b0;
    localparam logic             DIR_DOWN   = 1'b1;

    function automatic logic [LED_W-1:0] seed_of(input mode_t m);
        logic [LED_W-1:0] s;
        case (m)
            M_HOLD, M_LEFT, M_BOUNCE: s = LED_ONE;
            M_RIGHT:                  s = LED_MSB;
            M_ALT:                    s = ALT_SEED;
            default:                  s = '0;
        endcase
        return s;
    endfunction

    mode_t            mode_q, mode_nxt, mode_dec;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, limit;
    logic             dir_q, dir_nxt;
    logic [LED_W-1:0] led_nxt;
    logic             tick_nxt;
    logic             mode_chg, step, legal;

    assign MODE = mode_q;

    // Switch decode; anything not listed is OFF
    always_comb begin
        mode_dec = M_OFF;
        case (SW)
            4'b0001: mode_dec = M_HOLD;
            4'b0010: mode_dec = M_LEFT;
            4'b0100: mode_dec = M_RIGHT;
            4'b1000: mode_dec = M_ALT;
            4'b0110: mode_dec = M_BOUNCE;
            default: mode_dec = M_OFF;
        endcase
    end

    // Step qualification; >= lets a speed increase mid-count fire immediately
    always_comb begin
        limit    = LIMIT_BASE >> SPEED;
        mode_chg = (mode_dec != mode_q);
        step     = !mode_chg && !PAUSE && (cnt_q >= limit);
    end

    // Pattern legality for the current mode; illegal patterns reload the seed
    always_comb begin
        legal = 1'b0;
        case (mode_q)
            M_OFF:           legal = (LED == '0);
            M_HOLD:          legal = (LED == LED_ONE);
            M_LEFT, M_RIGHT: legal = $onehot(LED);
            M_ALT:           legal = (LED == ALT_SEED) || (LED == ~ALT_SEED);
            M_BOUNCE:        legal = $onehot(LED)
                                     && !(dir_q == DIR_UP   && LED == LED_MSB)
                                     && !(dir_q == DIR_DOWN && LED == LED_ONE);
            default:         legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mode_q <= M_OFF;
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            LED    <= '0;
            TICK   <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            cnt_q  <= cnt_nxt;
            dir_q  <= dir_nxt;
            LED    <= led_nxt;
            TICK   <= tick_nxt;
        end
    end

    // Next-state: mode follows the switches, prescaler restarts on mode change
    always_comb begin
        mode_nxt = mode_dec;
        cnt_nxt  = cnt_q;
        if (mode_chg || step) begin
            cnt_nxt = '0;
        end else if (!PAUSE) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // Output / datapath: pattern update, bounce direction and tick pulse
    always_comb begin
        led_nxt  = LED;
        dir_nxt  = dir_q;
        tick_nxt = 1'b0;
        if (mode_chg) begin
            led_nxt = seed_of(mode_dec);
            dir_nxt = DIR_UP;
        end else if (step) begin
            tick_nxt = 1'b1;
            if (!legal) begin
                led_nxt = seed_of(mode_q);
                dir_nxt = DIR_UP;
            end else begin
                case (mode_q)
                    M_LEFT:  led_nxt = {LED[LED_W-2:0], LED[LED_W-1]};
                    M_RIGHT: led_nxt = {LED[0], LED[LED_W-1:1]};
                    M_ALT:   led_nxt = ~LED;
                    M_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            led_nxt = LED << 1;
                            if (led_nxt == LED_MSB) dir_nxt = DIR_DOWN;
                        end else begin
                            led_nxt = LED >> 1;
                            if (led_nxt == LED_ONE) dir_nxt = DIR_UP;
                        end
                    end
                    default: led_nxt = seed_of(mode_q);
                endcase
            end
        end
    end

endmodule
